// File: rtl/mac_div_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// Master issues operands; slave returns quotient, remainder and status.
interface mac_div_if #(
    parameter int DW = 16,
    parameter int VW = 8
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/mac_div.sv
// Restoring divider: one quotient bit per clock, DW-bit dividend by VW-bit divisor.
// Results are registered and only change when an operation completes.
module mac_div #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic     clk,
    input  logic     clr_n,
    mac_div_if.slave bus
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] sh_q, sh_d;
    logic [VW:0]   rem_q, rem_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rmd_q, rmd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dz_q, dz_d;

    logic [VW+DW:0] win;
    logic [VW:0]    cand;
    logic [VW:0]    trial;
    logic           ge;

    // {remainder, dividend} shifted as one window
    assign win   = {rem_q, sh_q} << 1;
    assign cand  = win[VW+DW:DW];
    assign ge    = cand >= {1'b0, dvs_q};
    assign trial = cand - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        sh_d    = bus.dividend;
                        dvs_d   = bus.divisor;
                        rem_d   = '0;
                        cnt_d   = CW'(DW);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        quo_d   = '1;
                        rmd_d   = bus.dividend[VW-1:0];
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                sh_d  = win[DW-1:0] | DW'(ge);
                rem_d = ge ? trial : cand;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                // busy distinguishes a finished RUN from divide-by-zero
                if (busy_q) begin
                    quo_d  = sh_q;
                    rmd_d  = rem_q[VW-1:0];
                    dz_d   = 1'b0;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
    assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_mac_div.sv
// Self-checking bench for mac_div: directed cases, aborts, back-to-back
// and random operands against an arithmetic reference model.
module tb_mac_div;
    localparam int DW = 16;
    localparam int VW = 8;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mac_div_if #(.DW(DW), .VW(VW)) bus ();

    mac_div #(.DW(DW), .VW(VW)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus.slave)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic void model(
        input  logic [15:0] a,
        input  logic [7:0]  b,
        output logic [15:0] q,
        output logic [7:0]  r,
        output logic        z
    );
        if (b == 8'd0) begin
            q = 16'hFFFF;
            r = a[7:0];
            z = 1'b1;
        end else begin
            q = 16'(int'(a) / int'(b));
            r = 8'(int'(a) % int'(b));
            z = 1'b0;
        end
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                         input string nm);
        logic [15:0] eq, pq;
        logic [7:0]  er, pr;
        logic        ez;
        int idx, bc, lat_exp;
        bit seen, moved;
        model(a, b, eq, er, ez);
        lat_exp = (b == 8'd0) ? 0 : DW + 1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        pq = bus.quotient;
        pr = bus.remainder;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor = 8'($urandom);
        idx = 0; bc = 0; seen = 0; moved = 0;
        while (idx < 40 && !seen) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
            end else begin
                if (bus.busy) bc++;
                if (bus.quotient !== pq || bus.remainder !== pr) moved = 1;
                idx++;
            end
        end
        tests++;
        if (!seen || idx != lat_exp) begin
            fails++;
            $display("FAIL %s latency got %0d exp %0d", nm, idx, lat_exp);
        end
        tests++;
        if (bc != lat_exp || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s busy cycles got %0d exp %0d", nm, bc, lat_exp);
        end
        tests++;
        if (moved) begin
            fails++;
            $display("FAIL %s outputs changed before done got 1 exp 0", nm);
        end
        tests++;
        if (bus.quotient !== eq) begin
            fails++;
            $display("FAIL %s quotient got %0d exp %0d", nm, bus.quotient, eq);
        end
        tests++;
        if (bus.remainder !== er) begin
            fails++;
            $display("FAIL %s remainder got %0d exp %0d", nm, bus.remainder, er);
        end
        tests++;
        if (bus.div_zero !== ez) begin
            fails++;
            $display("FAIL %s div_zero got %0b exp %0b", nm, bus.div_zero, ez);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0 || bus.quotient !== eq) begin
            fails++;
            $display("FAIL %s done width/hold got done=%0b q=%0d exp 0/%0d",
                     nm, bus.done, bus.quotient, eq);
        end
    endtask

    task automatic check_zero(input string nm);
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
            fails++;
            $display("FAIL %s status got %0b%0b%0b exp 000", nm,
                     bus.busy, bus.done, bus.div_zero);
        end
        tests++;
        if (bus.quotient !== 16'd0 || bus.remainder !== 8'd0) begin
            fails++;
            $display("FAIL %s result got %0d/%0d exp 0/0", nm,
                     bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        clr_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("post_reset_idle");
    endtask

    task automatic test_directed();
        do_op(16'd120, 8'd10, "120/10");
        do_op(16'd1000, 8'd7, "1000/7");
        do_op(16'd5, 8'd200, "5/200");
        do_op(16'd65535, 8'd255, "65535/255");
        do_op(16'd65535, 8'd1, "65535/1");
    endtask

    task automatic test_div_zero();
        do_op(16'h1234, 8'd0, "1234h/0");
        do_op(16'd100, 8'd9, "100/9");
    endtask

    task automatic test_ignore_start();
        int pulses, bc, didx;
        logic [15:0] q;
        logic [7:0]  r;
        pulses = 0; bc = 0; didx = -1; q = '0; r = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor = 8'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (c == 2) begin
                bus.start = 1'b1;
                bus.dividend = 16'd50;
                bus.divisor = 8'd5;
            end
            if (c == 3) bus.start = 1'b0;
            if (c == 5) begin
                bus.dividend = 16'hBEEF;
                bus.divisor = 8'd3;
            end
            if (bus.busy) bc++;
            if (bus.done) begin
                pulses++;
                didx = c;
                q = bus.quotient;
                r = bus.remainder;
            end
        end
        tests++;
        if (pulses != 1 || didx != DW + 1) begin
            fails++;
            $display("FAIL ignore_start pulses got %0d@%0d exp 1@%0d",
                     pulses, didx, DW + 1);
        end
        tests++;
        if (q !== 16'd142 || r !== 8'd6) begin
            fails++;
            $display("FAIL ignore_start result got %0d/%0d exp 142/6", q, r);
        end
        tests++;
        if (bc != DW + 1) begin
            fails++;
            $display("FAIL ignore_start busy cycles got %0d exp %0d", bc, DW + 1);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor = 8'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(negedge clk);
        #2 clr_n = 1'b0;
        #1 check_zero("reset_mid");
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        tests++;
        if (pulses != 0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid stray pulses got %0d exp 0", pulses);
        end
        do_op(16'd81, 8'd9, "81/9");
    endtask

    task automatic test_back_to_back();
        int last, pulses;
        bit unstable, badgap;
        last = -1; pulses = 0; unstable = 0; badgap = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'd200;
        bus.divisor = 8'd3;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                if (last >= 0 && c - last != DW + 2) badgap = 1;
                last = c;
                tests++;
                if (bus.quotient !== 16'd66 || bus.remainder !== 8'd2) begin
                    fails++;
                    $display("FAIL b2b result got %0d/%0d exp 66/2",
                             bus.quotient, bus.remainder);
                end
            end else if (last >= 0) begin
                if (bus.quotient !== 16'd66 || bus.remainder !== 8'd2)
                    unstable = 1;
            end
        end
        bus.start = 1'b0;
        tests++;
        if (pulses != 4 || badgap) begin
            fails++;
            $display("FAIL b2b cadence got %0d pulses gap_err=%0b exp 4/0",
                     pulses, badgap);
        end
        tests++;
        if (unstable) begin
            fails++;
            $display("FAIL b2b hold got unstable=1 exp 0");
        end
        repeat (DW + 4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  b;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            do_op(a, b, $sformatf("rand%0d_%0d/%0d", i, a, b));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        test_reset();
        test_directed();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
